// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file with registered outputs, write-first
// bypass, optional hardwired-zero entry 0 and a sequential bulk-clear engine.
module register_file_2r1w #(
    parameter int             N         = 8,
    parameter int             ADDR_W    = 3,
    parameter logic [N-1:0]   RESET_VAL = '0,
    parameter bit             ZERO_REG  = 1'b0
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Enable,
    input  logic              Wr_en,
    input  logic [ADDR_W-1:0] Wr_addr,
    input  logic [N-1:0]      Data_in,
    input  logic              Rd_en,
    input  logic [ADDR_W-1:0] Rd_addr_a,
    input  logic [ADDR_W-1:0] Rd_addr_b,
    output logic [N-1:0]      Data_out_a,
    output logic [N-1:0]      Data_out_b,
    output logic              Rd_valid,
    input  logic              Clear_req,
    output logic              Busy,
    output logic              Clear_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    logic [N-1:0]      mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              wr_go;
    logic              wr_mem;
    logic              rd_go;
    logic [N-1:0]      rd_a;
    logic [N-1:0]      rd_b;

    assign wr_go  = Enable & Wr_en & ~Busy;
    assign wr_mem = wr_go & ~(ZERO_REG && (Wr_addr == '0));
    assign rd_go  = Enable & Rd_en & ~Busy;

    // Write-first bypass, with the hardwired zero taking priority.
    always_comb begin
        rd_a = mem[Rd_addr_a];
        if (wr_go && (Wr_addr == Rd_addr_a)) rd_a = Data_in;
        if (ZERO_REG && (Rd_addr_a == '0)) rd_a = '0;
    end

    always_comb begin
        rd_b = mem[Rd_addr_b];
        if (wr_go && (Wr_addr == Rd_addr_b)) rd_b = Data_in;
        if (ZERO_REG && (Rd_addr_b == '0)) rd_b = '0;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else if (Enable) begin
            if (state == CLEAR) mem[ptr] <= RESET_VAL;
            else if (wr_mem) mem[Wr_addr] <= Data_in;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Data_out_a <= '0;
            Data_out_b <= '0;
            Rd_valid   <= 1'b0;
        end else if (rd_go) begin
            Data_out_a <= rd_a;
            Data_out_b <= rd_b;
            Rd_valid   <= 1'b1;
        end else begin
            Rd_valid   <= 1'b0;
        end
    end

    // Busy falls on the edge that clears the last entry, so DONE is the
    // single cycle in which Clear_done is visible.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            ptr        <= '0;
            Busy       <= 1'b0;
            Clear_done <= 1'b0;
        end else begin
            Clear_done <= 1'b0;
            if (Enable) begin
                unique case (state)
                    IDLE: begin
                        if (Clear_req) begin
                            state <= CLEAR;
                            ptr   <= '0;
                            Busy  <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        ptr <= ptr + 1'b1;
                        if (ptr == '1) begin
                            state      <= DONE;
                            Busy       <= 1'b0;
                            Clear_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: three instances (plain, zero-reg,
// RESET_VAL=0x5A) share one stimulus stream.
module tb_register_file_2r1w;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic       en = 1'b0;
    logic       we = 1'b0;
    logic [2:0] wa = '0;
    logic [7:0] din = '0;
    logic       re = 1'b0;
    logic [2:0] ra = '0;
    logic [2:0] rb = '0;
    logic       cr = 1'b0;

    logic [7:0] a0, b0, az, bz, ac, bc;
    logic       v0, vz, vc, busy0, busyz, busyc, done0, donez, donec;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    register_file_2r1w #(.N(8), .ADDR_W(3)) dut0 (
        .Clk(Clk), .nReset(nReset), .Enable(en), .Wr_en(we), .Wr_addr(wa),
        .Data_in(din), .Rd_en(re), .Rd_addr_a(ra), .Rd_addr_b(rb),
        .Data_out_a(a0), .Data_out_b(b0), .Rd_valid(v0),
        .Clear_req(cr), .Busy(busy0), .Clear_done(done0)
    );

    register_file_2r1w #(.N(8), .ADDR_W(3), .ZERO_REG(1'b1)) dutz (
        .Clk(Clk), .nReset(nReset), .Enable(en), .Wr_en(we), .Wr_addr(wa),
        .Data_in(din), .Rd_en(re), .Rd_addr_a(ra), .Rd_addr_b(rb),
        .Data_out_a(az), .Data_out_b(bz), .Rd_valid(vz),
        .Clear_req(cr), .Busy(busyz), .Clear_done(donez)
    );

    register_file_2r1w #(.N(8), .ADDR_W(3), .RESET_VAL(8'h5A)) dutc (
        .Clk(Clk), .nReset(nReset), .Enable(en), .Wr_en(we), .Wr_addr(wa),
        .Data_in(din), .Rd_en(re), .Rd_addr_a(ra), .Rd_addr_b(rb),
        .Data_out_a(ac), .Data_out_b(bc), .Rd_valid(vc),
        .Clear_req(cr), .Busy(busyc), .Clear_done(donec)
    );

    task automatic cyc(input logic w, input logic [2:0] wad, input logic [7:0] d,
                       input logic r, input logic [2:0] rad, input logic [2:0] rbd,
                       input logic c);
        @(negedge Clk);
        we = w; wa = wad; din = d; re = r; ra = rad; rb = rbd; cr = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        en = 1'b1;
        #15;
        checks++; if (a0 !== 8'h00 || b0 !== 8'h00) begin errors++; $display("FAIL rst_out a=%h b=%h exp=00", a0, b0); end
        checks++; if ({v0, busy0, done0} !== 3'b000) begin errors++; $display("FAIL rst_flags vbd=%b exp=000", {v0, busy0, done0}); end
        @(negedge Clk);
        nReset = 1'b1;
        cyc(0, 0, 0, 1, 3'd2, 3'd5, 0);
        checks++; if (a0 !== 8'h00 || b0 !== 8'h00 || v0 !== 1'b1) begin errors++; $display("FAIL rst_read a=%h b=%h v=%b exp=00/00/1", a0, b0, v0); end
        checks++; if (ac !== 8'h5A || bc !== 8'h5A) begin errors++; $display("FAIL rst_read_c a=%h b=%h exp=5a", ac, bc); end
    endtask

    task automatic test_fill_dual_read();
        for (int i = 0; i < 8; i++) cyc(1, 3'(i), 8'(i + 1), 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3'd3, 3'd7, 0);
        checks++; if (a0 !== 8'h04 || b0 !== 8'h08 || v0 !== 1'b1) begin errors++; $display("FAIL fill_rd a=%h b=%h v=%b exp=04/08/1", a0, b0, v0); end
        cyc(0, 0, 0, 1, 3'd6, 3'd6, 0);
        checks++; if (a0 !== 8'h07 || b0 !== 8'h07) begin errors++; $display("FAIL same_addr a=%h b=%h exp=07/07", a0, b0); end
        cyc(0, 0, 0, 0, 3'd1, 3'd1, 0);
        checks++; if (v0 !== 1'b0 || a0 !== 8'h07) begin errors++; $display("FAIL no_rd v=%b a=%h exp=0/07", v0, a0); end
    endtask

    task automatic test_bypass();
        cyc(1, 3'd4, 8'hAA, 1, 3'd4, 3'd3, 0);
        checks++; if (a0 !== 8'hAA || b0 !== 8'h04) begin errors++; $display("FAIL bypass a=%h b=%h exp=aa/04", a0, b0); end
        cyc(0, 0, 0, 1, 3'd4, 3'd4, 0);
        checks++; if (a0 !== 8'hAA || b0 !== 8'hAA) begin errors++; $display("FAIL bypass_later a=%h b=%h exp=aa/aa", a0, b0); end
    endtask

    task automatic test_zero_reg();
        cyc(1, 3'd0, 8'h55, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3'd0, 3'd0, 0);
        checks++; if (az !== 8'h00) begin errors++; $display("FAIL zero_rd a=%h exp=00", az); end
        checks++; if (a0 !== 8'h55) begin errors++; $display("FAIL plain_rd0 a=%h exp=55", a0); end
        cyc(1, 3'd1, 8'h33, 1, 3'd0, 3'd1, 0);
        checks++; if (az !== 8'h00 || bz !== 8'h33) begin errors++; $display("FAIL zero_byp a=%h b=%h exp=00/33", az, bz); end
        cyc(1, 3'd0, 8'h77, 1, 3'd0, 3'd0, 0);
        checks++; if (az !== 8'h00 || a0 !== 8'h77) begin errors++; $display("FAIL zero_byp0 z=%h p=%h exp=00/77", az, a0); end
    endtask

    task automatic test_bulk_clear();
        int n;
        logic v_seen;
        cyc(0, 0, 0, 0, 0, 0, 1);
        checks++; if (busyc !== 1'b1) begin errors++; $display("FAIL clr_start busy=%b exp=1", busyc); end
        n = 1;
        v_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc(1, 3'(k), 8'hEE, 1, 3'(k), 3'(k + 1), 0);
            if (busyc !== 1'b1) break;
            n++;
            if (vc !== 1'b0) v_seen = 1'b1;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL clr_len busy_cycles=%0d exp=8", n); end
        checks++; if (v_seen !== 1'b0) begin errors++; $display("FAIL clr_rdvalid seen=%b exp=0", v_seen); end
        checks++; if (donec !== 1'b1) begin errors++; $display("FAIL clr_done done=%b exp=1", donec); end
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (donec !== 1'b0 || busyc !== 1'b0) begin errors++; $display("FAIL clr_pulse done=%b busy=%b exp=0/0", donec, busyc); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 3'(i), 3'(i + 4), 0);
            checks++; if (ac !== 8'h5A || bc !== 8'h5A) begin errors++; $display("FAIL clr_val i=%0d a=%h b=%h exp=5a", i, ac, bc); end
            checks++; if (a0 !== 8'h00 || b0 !== 8'h00) begin errors++; $display("FAIL clr_val0 i=%0d a=%h b=%h exp=00", i, a0, b0); end
        end
    endtask

    task automatic test_enable_stretch();
        int n;
        cyc(0, 0, 0, 0, 0, 0, 1);
        n = 1;
        for (int k = 0; k < 30; k++) begin
            en = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (busyc !== 1'b1) break;
            n++;
        end
        en = 1'b1;
        checks++; if (n !== 11) begin errors++; $display("FAIL en_stretch busy_cycles=%0d exp=11", n); end
        checks++; if (donec !== 1'b1) begin errors++; $display("FAIL en_done done=%b exp=1", donec); end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_clear();
        logic bad;
        cyc(1, 3'd7, 8'h11, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        #2 nReset = 1'b0;
        #1;
        checks++; if (busyc !== 1'b0 || donec !== 1'b0) begin errors++; $display("FAIL mid_rst busy=%b done=%b exp=0/0", busyc, donec); end
        @(negedge Clk);
        nReset = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (busyc !== 1'b0 || donec !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_rst_idle bad=%b exp=0", bad); end
        cyc(0, 0, 0, 1, 3'd7, 3'd0, 0);
        checks++; if (ac !== 8'h5A || bc !== 8'h5A) begin errors++; $display("FAIL mid_rst_val a=%h b=%h exp=5a", ac, bc); end
    endtask

    task automatic test_clear_with_access();
        int k;
        cyc(1, 3'd2, 8'h99, 1, 3'd2, 3'd2, 1);
        checks++; if (ac !== 8'h99 || vc !== 1'b1 || busyc !== 1'b1) begin errors++; $display("FAIL clr_acc a=%h v=%b busy=%b exp=99/1/1", ac, vc, busyc); end
        k = 0;
        while (busyc === 1'b1 && k < 30) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            k++;
        end
        checks++; if (donec !== 1'b1 || k !== 8) begin errors++; $display("FAIL clr_acc_done done=%b cycles=%0d exp=1/8", donec, k); end
        cyc(0, 0, 0, 1, 3'd2, 3'd2, 0);
        checks++; if (ac !== 8'h5A) begin errors++; $display("FAIL clr_acc_val a=%h exp=5a", ac); end
    endtask

    initial begin
        test_reset();
        test_fill_dual_read();
        test_bypass();
        test_zero_reg();
        test_bulk_clear();
        test_enable_stretch();
        test_reset_mid_clear();
        test_clear_with_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised N-bit register file: 2^ADDR_W entries, one write port, two independent read ports.
- Read outputs are registered, with write-first bypass.
- Optional hardwired-zero entry 0.
- Sequential bulk-clear engine that walks every entry back to RESET_VAL under a busy/done handshake.
- Serves as the general-purpose register storage for datapath blocks that need two operands per cycle.

Parameters:
- N, 8, data width in bits.
- ADDR_W, 3, address width; depth = 2^ADDR_W entries.
- RESET_VAL, 0, value of every entry after reset or bulk clear (N bits).
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes.

Ports:
- Clk  in  1  clock, rising-edge active.
- nReset  in  1  asynchronous active-low reset.
- Enable  in  1  global enable; 0 freezes all state.
- Wr_en  in  1  write request.
- Wr_addr  in  ADDR_W  write address.
- Data_in  in  N  write data.
- Rd_en  in  1  read request, both ports.
- Rd_addr_a  in  ADDR_W  read address, port A.
- Rd_addr_b  in  ADDR_W  read address, port B.
- Data_out_a  out  N  registered read data, port A.
- Data_out_b  out  N  registered read data, port B.
- Rd_valid  out  1  high the cycle after an accepted read.
- Clear_req  in  1  bulk-clear request, sampled on a level basis.
- Busy  out  1  high while the clear engine runs.
- Clear_done  out  1  one-cycle pulse when a clear completes.

Behaviour:
- Reset (nReset=0, asynchronous):
  - All entries = RESET_VAL.
  - Data_out_a/b = 0; Rd_valid = 0; Busy = 0; Clear_done = 0.
  - FSM = IDLE; clear pointer = 0.
  - Takes effect immediately; a clear in progress is aborted.
- Enable=0: no entry, output, pointer or FSM state changes. Exception: Rd_valid and Clear_done drop to 0 at the next edge.
- Write is accepted at a rising edge when Enable=1, Wr_en=1 and Busy=0.
  - Effect: entry[Wr_addr] <= Data_in.
  - If ZERO_REG=1 and Wr_addr=0, the write is discarded.
- Read is accepted at a rising edge when Enable=1, Rd_en=1 and Busy=0.
  - Data_out_a <= entry[Rd_addr_a] and Data_out_b <= entry[Rd_addr_b]; Rd_valid <= 1.
  - Latency: 1 clock from address presentation.
  - Otherwise Rd_valid <= 0 and Data_out_a/b hold their last value.
- Bypass: on a simultaneous accepted write and read to the same address, the read port returns Data_in (write-first).
  - Applies per port independently; both ports may hit the same address.
  - With ZERO_REG=1, address 0 returns 0 even under bypass.
- ZERO_REG=1: any read of address 0 returns 0, regardless of RESET_VAL.
- Clear FSM (advances only when Enable=1):
  - IDLE: Clear_req=1 -> CLEAR, pointer = 0, Busy <= 1.
  - CLEAR: entry[pointer] <= RESET_VAL and pointer increments each cycle. After writing entry 2^ADDR_W-1 -> DONE.
  - DONE: Busy <= 0, Clear_done <= 1 for exactly one cycle -> IDLE.
  - Clear duration: 2^ADDR_W cycles of Busy=1, then a 1-cycle Clear_done pulse.
  - Pointer wraps 2^ADDR_W-1 -> 0 without overflow state.
  - Clear_req while in CLEAR or DONE is ignored.
  - Clear_req still high in IDLE after DONE starts a new clear.
- Simultaneous Clear_req and write/read in IDLE:
  - The write and read of that cycle are accepted.
  - Busy rises at the same edge.
  - The clear then overwrites the written entry.
- While Busy=1:
  - Write and read requests are ignored; Rd_valid=0.
  - Data_out_a/b hold their value.
- Data_out_a/b are always registered; no combinational path from inputs to outputs.

Test Plan:
- Reset and read-back: nReset=0 for 15 ns, release; read addresses 2 (A) and 5 (B) -> Data_out_a = Data_out_b = 0x00, Rd_valid=1 one cycle later.
- Fill and dual read: write 0x01..0x08 to addresses 0..7; read A=3, B=7 -> 0x04 / 0x08. Read A=B=6 -> both 0x07.
- Bypass: entry 4 holds 0x05; same edge write 0xAA to address 4 and read A=4, B=3 -> Data_out_a=0xAA, Data_out_b=0x04. A later read of 4 also returns 0xAA.
- ZERO_REG=1 instance: write 0x55 to address 0, read A=0 -> 0x00. Write 0x33 to address 1 with a same-cycle read of A=0, B=1 -> 0x00 / 0x33.
- Bulk clear with RESET_VAL=0x5A:
  - Pulse Clear_req -> Busy high for exactly 8 cycles, then Clear_done one cycle.
  - Writes during Busy are ignored; all 8 entries read 0x5A afterwards.
  - Enable=0 mid-clear stretches Busy by the number of disabled cycles.
- Reset mid-clear: assert nReset=0 at clear cycle 3 -> Busy=0 immediately, no Clear_done pulse, all entries = RESET_VAL, FSM restarts in IDLE.
